ram_rr_arbiter: RTL and testbench
=================================

RAM_RR_ARBITER -- requirements
Module: ram_rr_arbiter

Interface
REQ-001 Parameters SHALL be:
- WORD_WIDTH, default 8, RAM word width in bits.
- WORD_COUNT, default 256, RAM depth.
- NUM_REQ, default 4, number of requesters (2..16).
- ADDR_WIDTH, localparam, $clog2(WORD_COUNT).
REQ-002 The block SHALL have one clock; reset SHALL be asynchronous and active-high.
REQ-003 Ports SHALL be:
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  asynchronous active-high reset.
- wr_req_i  in  NUM_REQ  per-requester write request.
- wr_addr_i  in  NUM_REQ x ADDR_WIDTH  write addresses.
- wr_data_i  in  NUM_REQ x WORD_WIDTH  write data.
- wr_gnt_o  out  NUM_REQ  one-hot write grant.
- rd_req_i  in  NUM_REQ  per-requester read request.
- rd_addr_i  in  NUM_REQ x ADDR_WIDTH  read addresses.
- rd_gnt_o  out  NUM_REQ  one-hot read grant.
- rd_valid_o  out  NUM_REQ  one-hot read-data valid.
- rd_data_o  out  WORD_WIDTH  shared read data bus.
- ram_we_o  out  1  RAM write enable (port a).
- ram_waddr_o  out  ADDR_WIDTH  RAM write address.
- ram_wdata_o  out  WORD_WIDTH  RAM write data.
- ram_raddr_o  out  ADDR_WIDTH  RAM read address (port b).
- ram_rdata_i  in  WORD_WIDTH  RAM registered read data, 1-cycle latency.

Function
REQ-004 Write and read ports SHALL be arbitrated independently; one write grant and one read grant MAY occur in the same cycle.
REQ-005 Each port SHALL use round-robin arbitration with a registered priority pointer ptr (0..NUM_REQ-1).
REQ-006 The grant SHALL go to the first requester asserting req, searching from index ptr upward with wrap-around from NUM_REQ-1 to 0.
REQ-007 Grants SHALL be combinational from req and ptr; at most one bit set; all zero when no req.
REQ-008 A transfer SHALL complete in the cycle where req and gnt are both high; the requester SHALL hold req, addr and data stable until granted.
REQ-009 After a grant to index i, ptr SHALL become (i+1) mod NUM_REQ at the next edge; with no grant, ptr SHALL hold.
REQ-010 Any continuously requesting requester SHALL be granted within NUM_REQ cycles.
REQ-011 ram_we_o SHALL equal |wr_gnt_o; ram_waddr_o and ram_wdata_o SHALL be the granted requester's values, and 0 when ram_we_o is low.
REQ-012 ram_raddr_o SHALL be the granted reader's address, and 0 when no read grant.
REQ-013 rd_valid_o SHALL be rd_gnt_o registered by one cycle; rd_data_o SHALL equal ram_rdata_i, qualified only by rd_valid_o.
REQ-014 When a read and a write to the same address are granted in the same cycle, the read SHALL return the old word (read-first), and the block SHALL NOT forward the write data.
REQ-015 Back-to-back grants to the same requester SHALL be permitted only when no other requester is active.
REQ-016 Reads SHALL be fully pipelined at one grant per cycle, with rd_valid_o following each grant by exactly one cycle.

Reset
REQ-017 While rst_i is high, both ptr registers and rd_valid_o SHALL be 0, and the grant outputs SHALL still reflect requests using ptr=0.
REQ-018 An in-flight read SHALL be dropped when rst_i asserts: rd_valid_o SHALL be 0 in the following cycle, with no late response after reset release.
REQ-019 Reset SHALL NOT alter RAM contents.

Structure
REQ-020 A package ram_arb_pkg SHALL hold the NUM_REQ bound constant (16) and a function computing the next pointer.
REQ-021 A sub-module rr_arbiter (parameter N; ports req, gnt, ptr register inside) SHALL be instantiated twice, once for writes and once for reads.
REQ-022 Total RTL SHALL be 120-400 lines; the RAM itself SHALL be instantiated outside this block.

Verification
REQ-023 Write fairness: NUM_REQ=4, wr_req_i=4'b1111 held for 8 cycles from reset -> wr_gnt_o sequence 0001,0010,0100,1000,0001,0010,0100,1000.
REQ-024 Skip and wrap: ptr=2, rd_req_i=4'b0011 -> grant 0001, next cycle grant 0010, then ptr=2 and grant 0001 again if still requested.
REQ-025 Read latency: requester 3 reads addr 0x10 holding 0xA5 -> rd_gnt_o=1000 at cycle t; at t+1 rd_valid_o=1000 and rd_data_o=0xA5.
REQ-026 Read-first collision: requester 0 writes 0x5A to 0x20 (old 0x11) while requester 1 reads 0x20 in the same cycle -> read returns 0x11; a re-read returns 0x5A.
REQ-027 Reset mid-read: assert rst_i in the cycle after a read grant -> rd_valid_o=0, both ptr=0, no response after release.
REQ-028 Idle: all req low -> all grants 0, ram_we_o=0, ram_waddr_o/ram_wdata_o/ram_raddr_o=0, ptr unchanged.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared constants and pointer helper for the round-robin RAM arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// MAX_REQ bounds the requester count; PTR_MAX_W is wide enough for any
// pointer up to MAX_REQ-1, so next_ptr works for every legal N.
package ram_arb_pkg;

    localparam int MAX_REQ   = 16;
    localparam int PTR_MAX_W = 4;

    // Pointer that follows a grant to idx, wrapping at n.
    function automatic logic [PTR_MAX_W-1:0] next_ptr(
        input logic [PTR_MAX_W-1:0] idx,
        input logic [PTR_MAX_W:0]   n
    );
        logic [PTR_MAX_W:0] w_inc;
        w_inc = {1'b0, idx} + (PTR_MAX_W+1)'(1);
        return (w_inc >= n) ? '0 : w_inc[PTR_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, registered priority pointer.
// Latency: grant is combinational from req and ptr; ptr updates at the next edge.
// Backpressure: a requester holds req until granted; losers simply wait.
//
// Ports:
//   clk  in  1  clock
//   rst  in  1  asynchronous active-high reset (ptr -> 0)
//   req  in  N  request vector
//   gnt  out N  one-hot grant, zero when no request
module rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_gnt_idx;
    logic          w_found;

    // Two passes stand in for a rotating search: first ptr..N-1, then
    // wrap to 0..ptr-1. The first hit wins.
    always_comb begin
        gnt       = '0;
        w_gnt_idx = '0;
        w_found   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!w_found && req[i] && (i >= int'(r_ptr))) begin
                gnt[i]    = 1'b1;
                w_gnt_idx = PW'(i);
                w_found   = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!w_found && req[i] && (i < int'(r_ptr))) begin
                gnt[i]    = 1'b1;
                w_gnt_idx = PW'(i);
                w_found   = 1'b1;
            end
        end
    end

    // Pointer moves just past the winner; holds when nobody was granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= PW'(next_ptr(PTR_MAX_W'(w_gnt_idx), (PTR_MAX_W+1)'(N)));
        end
    end

endmodule

// File: rtl/ram_rr_arbiter.sv
// Multi-requester front end for a dual-port RAM: independent round-robin
// arbitration of the write port (a) and the read port (b).
// Latency: write/read grants combinational; read data valid one cycle after grant.
// Backpressure: requesters hold req/addr/data until their grant; no queuing here.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   wr_req_i/addr/data      per-requester write requests -> wr_gnt_o (one-hot)
//   rd_req_i/addr           per-requester read requests  -> rd_gnt_o (one-hot)
//   rd_valid_o, rd_data_o   one-hot read return and shared data bus
//   ram_*                   external RAM: write port a, registered read port b
module ram_rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter  int WORD_WIDTH = 8,
    parameter  int WORD_COUNT = 256,
    parameter  int NUM_REQ    = 4,
    localparam int ADDR_WIDTH = $clog2(WORD_COUNT)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NUM_REQ-1:0]                   wr_req_i,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   wr_addr_i,
    input  logic [NUM_REQ-1:0][WORD_WIDTH-1:0]   wr_data_i,
    output logic [NUM_REQ-1:0]                   wr_gnt_o,
    input  logic [NUM_REQ-1:0]                   rd_req_i,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   rd_addr_i,
    output logic [NUM_REQ-1:0]                   rd_gnt_o,
    output logic [NUM_REQ-1:0]                   rd_valid_o,
    output logic [WORD_WIDTH-1:0]                rd_data_o,
    output logic                                 ram_we_o,
    output logic [ADDR_WIDTH-1:0]                ram_waddr_o,
    output logic [WORD_WIDTH-1:0]                ram_wdata_o,
    output logic [ADDR_WIDTH-1:0]                ram_raddr_o,
    input  logic [WORD_WIDTH-1:0]                ram_rdata_i
);

    logic [NUM_REQ-1:0]    w_wr_gnt;
    logic [NUM_REQ-1:0]    w_rd_gnt;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [WORD_WIDTH-1:0] w_wdata;
    logic [ADDR_WIDTH-1:0] w_raddr;
    logic [NUM_REQ-1:0]    r_rd_valid;

    rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
        .clk (clk_i),
        .rst (rst_i),
        .req (wr_req_i),
        .gnt (w_wr_gnt)
    );

    rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
        .clk (clk_i),
        .rst (rst_i),
        .req (rd_req_i),
        .gnt (w_rd_gnt)
    );

    // Grants are one-hot, so an AND-OR mux gives the winner's fields and
    // naturally drives zero when nothing is granted.
    always_comb begin
        w_waddr = '0;
        w_wdata = '0;
        w_raddr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_waddr = w_waddr | (wr_addr_i[i] & {ADDR_WIDTH{w_wr_gnt[i]}});
            w_wdata = w_wdata | (wr_data_i[i] & {WORD_WIDTH{w_wr_gnt[i]}});
            w_raddr = w_raddr | (rd_addr_i[i] & {ADDR_WIDTH{w_rd_gnt[i]}});
        end
    end

    // Tracks the RAM's one-cycle read latency. Reset kills any in-flight
    // return so nothing surfaces after release.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rd_valid <= '0;
        end else begin
            r_rd_valid <= w_rd_gnt;
        end
    end

    assign wr_gnt_o    = w_wr_gnt;
    assign rd_gnt_o    = w_rd_gnt;
    assign ram_we_o    = |w_wr_gnt;
    assign ram_waddr_o = w_waddr;
    assign ram_wdata_o = w_wdata;
    assign ram_raddr_o = w_raddr;
    assign rd_valid_o  = r_rd_valid;
    // The RAM is read-first; its data passes straight through, no forwarding.
    assign rd_data_o   = (|r_rd_valid) ? ram_rdata_i : '0;

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Directed testbench for ram_rr_arbiter with a read-first registered RAM model.
module tb_ram_rr_arbiter;

    logic            clk;
    logic            rst;
    logic [3:0]      wr_req;
    logic [3:0][7:0] wr_addr;
    logic [3:0][7:0] wr_data;
    logic [3:0]      wr_gnt;
    logic [3:0]      rd_req;
    logic [3:0][7:0] rd_addr;
    logic [3:0]      rd_gnt;
    logic [3:0]      rd_valid;
    logic [7:0]      rd_data;
    logic            ram_we;
    logic [7:0]      ram_waddr;
    logic [7:0]      ram_wdata;
    logic [7:0]      ram_raddr;
    logic [7:0]      ram_rdata;

    int checks   = 0;
    int failures = 0;

    ram_rr_arbiter #(
        .WORD_WIDTH (8),
        .WORD_COUNT (256),
        .NUM_REQ    (4)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .wr_req_i    (wr_req),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
        .wr_gnt_o    (wr_gnt),
        .rd_req_i    (rd_req),
        .rd_addr_i   (rd_addr),
        .rd_gnt_o    (rd_gnt),
        .rd_valid_o  (rd_valid),
        .rd_data_o   (rd_data),
        .ram_we_o    (ram_we),
        .ram_waddr_o (ram_waddr),
        .ram_wdata_o (ram_wdata),
        .ram_raddr_o (ram_raddr),
        .ram_rdata_i (ram_rdata)
    );

    // External RAM: registered read-first read port, synchronous write port.
    logic [7:0] mem [256];
    always @(posedge clk) begin
        ram_rdata <= mem[ram_raddr];
        if (ram_we) mem[ram_waddr] <= ram_wdata;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        wr_req  = '0;
        rd_req  = '0;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (rd_valid !== 4'b0000) begin
            failures++; $display("FAIL reset_rd_valid got=%b exp=0000", rd_valid);
        end
        checks++;
        if (ram_we !== 1'b0 || wr_gnt !== 4'b0000 || rd_gnt !== 4'b0000) begin
            failures++; $display("FAIL reset_idle we=%b wg=%b rg=%b exp=0/0000/0000", ram_we, wr_gnt, rd_gnt);
        end
        // Grants still live during reset, using ptr=0.
        wr_req = 4'b1111;
        rd_req = 4'b0110;
        #1;
        checks++;
        if (wr_gnt !== 4'b0001) begin
            failures++; $display("FAIL reset_wr_gnt got=%b exp=0001", wr_gnt);
        end
        checks++;
        if (rd_gnt !== 4'b0010) begin
            failures++; $display("FAIL reset_rd_gnt got=%b exp=0010", rd_gnt);
        end
        tick();
        clear_inputs();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write_fairness();
        logic [3:0] exp_seq [8];
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                    4'b0001, 4'b0010, 4'b0100, 4'b1000};
        for (int i = 0; i < 4; i++) begin
            wr_addr[i] = 8'h40 + 8'(i);
            wr_data[i] = 8'hC0 + 8'(i);
        end
        wr_req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++;
            if (wr_gnt !== exp_seq[k]) begin
                failures++; $display("FAIL fair_gnt[%0d] got=%b exp=%b", k, wr_gnt, exp_seq[k]);
            end
            checks++;
            if (ram_we !== 1'b1 || ram_waddr !== 8'h40 + 8'(k % 4) || ram_wdata !== 8'hC0 + 8'(k % 4)) begin
                failures++; $display("FAIL fair_ram[%0d] we=%b a=%h d=%h exp=1/%h/%h", k, ram_we,
                                     ram_waddr, ram_wdata, 8'h40 + 8'(k % 4), 8'hC0 + 8'(k % 4));
            end
            tick();
        end
        clear_inputs();
        tick();
    endtask

    task automatic do_write(input int idx, input logic [7:0] a, input logic [7:0] d);
        wr_req = '0;
        wr_req[idx] = 1'b1;
        wr_addr[idx] = a;
        wr_data[idx] = d;
        #1;
        checks++;
        if (ram_we !== 1'b1 || ram_waddr !== a || ram_wdata !== d) begin
            failures++; $display("FAIL write_%0d we=%b a=%h d=%h exp=1/%h/%h", idx, ram_we, ram_waddr, ram_wdata, a, d);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_idle();
        // Leaves write ptr at 3 (last grant to requester 2).
        do_write(3, 8'h20, 8'h11);
        do_write(2, 8'h10, 8'hA5);
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (wr_gnt !== 4'b0 || rd_gnt !== 4'b0 || ram_we !== 1'b0 || ram_waddr !== 8'h0 ||
                ram_wdata !== 8'h0 || ram_raddr !== 8'h0 || rd_valid !== 4'b0) begin
                failures++; $display("FAIL idle[%0d] wg=%b rg=%b we=%b wa=%h wd=%h ra=%h rv=%b exp=all zero",
                                     k, wr_gnt, rd_gnt, ram_we, ram_waddr, ram_wdata, ram_raddr, rd_valid);
            end
        end
        // Pointer must have held at 3 through the idle cycles.
        wr_req = 4'b1111;
        #1;
        checks++;
        if (wr_gnt !== 4'b1000) begin
            failures++; $display("FAIL idle_ptr_hold got=%b exp=1000", wr_gnt);
        end
        wr_req = 4'b0000;
        tick();
    endtask

    task automatic test_read_latency();
        rd_req = 4'b1000;
        rd_addr[3] = 8'h10;
        #1;
        checks++;
        if (rd_gnt !== 4'b1000 || ram_raddr !== 8'h10) begin
            failures++; $display("FAIL lat_gnt got=%b/%h exp=1000/10", rd_gnt, ram_raddr);
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (rd_valid !== 4'b1000 || rd_data !== 8'hA5) begin
            failures++; $display("FAIL lat_data got=%b/%h exp=1000/a5", rd_valid, rd_data);
        end
        tick();
        checks++;
        if (rd_valid !== 4'b0000 || rd_data !== 8'h00) begin
            failures++; $display("FAIL lat_done got=%b/%h exp=0000/00", rd_valid, rd_data);
        end
    endtask

    task automatic test_skip_wrap();
        // Read ptr is 0; a grant to requester 1 moves it to 2.
        rd_req = 4'b0010;
        rd_addr[1] = 8'h10;
        #1;
        checks++;
        if (rd_gnt !== 4'b0010) begin
            failures++; $display("FAIL wrap_setup got=%b exp=0010", rd_gnt);
        end
        tick();
        rd_req = 4'b0011;
        rd_addr[0] = 8'h20;
        #1;
        checks++;
        if (rd_gnt !== 4'b0001) begin
            failures++; $display("FAIL wrap_first got=%b exp=0001", rd_gnt);
        end
        tick();
        checks++;
        if (rd_gnt !== 4'b0010) begin
            failures++; $display("FAIL wrap_second got=%b exp=0010", rd_gnt);
        end
        tick();
        checks++;
        if (rd_gnt !== 4'b0001) begin
            failures++; $display("FAIL wrap_third got=%b exp=0001", rd_gnt);
        end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_collision();
        wr_req = 4'b0001;
        wr_addr[0] = 8'h20;
        wr_data[0] = 8'h5A;
        rd_req = 4'b0010;
        rd_addr[1] = 8'h20;
        #1;
        checks++;
        if (wr_gnt !== 4'b0001 || rd_gnt !== 4'b0010 || ram_raddr !== 8'h20 || ram_waddr !== 8'h20) begin
            failures++; $display("FAIL coll_gnt wg=%b rg=%b ra=%h wa=%h exp=0001/0010/20/20",
                                 wr_gnt, rd_gnt, ram_raddr, ram_waddr);
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (rd_valid !== 4'b0010 || rd_data !== 8'h11) begin
            failures++; $display("FAIL coll_old got=%b/%h exp=0010/11", rd_valid, rd_data);
        end
        rd_req = 4'b0010;
        rd_addr[1] = 8'h20;
        tick();
        clear_inputs();
        #1;
        checks++;
        if (rd_valid !== 4'b0010 || rd_data !== 8'h5A) begin
            failures++; $display("FAIL coll_new got=%b/%h exp=0010/5a", rd_valid, rd_data);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_gnt [4];
        logic [7:0] exp_dat [4];
        // Read ptr is 2 after the re-read by requester 1.
        exp_gnt = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};
        exp_dat = '{8'hC2, 8'hC3, 8'h5A, 8'hC1};
        rd_addr[0] = 8'h20;
        rd_addr[1] = 8'h41;
        rd_addr[2] = 8'h42;
        rd_addr[3] = 8'h43;
        rd_req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (rd_gnt !== exp_gnt[k]) begin
                failures++; $display("FAIL pipe_gnt[%0d] got=%b exp=%b", k, rd_gnt, exp_gnt[k]);
            end
            if (k > 0) begin
                checks++;
                if (rd_valid !== exp_gnt[k-1] || rd_data !== exp_dat[k-1]) begin
                    failures++; $display("FAIL pipe_data[%0d] got=%b/%h exp=%b/%h", k, rd_valid, rd_data,
                                         exp_gnt[k-1], exp_dat[k-1]);
                end
            end
            tick();
        end
        rd_req = 4'b0000;
        #1;
        checks++;
        if (rd_valid !== 4'b0010 || rd_data !== 8'hC1) begin
            failures++; $display("FAIL pipe_last got=%b/%h exp=0010/c1", rd_valid, rd_data);
        end
        // A lone requester may be granted on consecutive cycles.
        rd_req = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (rd_gnt !== 4'b0001) begin
                failures++; $display("FAIL b2b_gnt[%0d] got=%b exp=0001", k, rd_gnt);
            end
            tick();
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid_read();
        // Bring read ptr to 3 so a reset to 0 is observable.
        rd_req = 4'b0100;
        rd_addr[2] = 8'h42;
        #1;
        checks++;
        if (rd_gnt !== 4'b0100) begin
            failures++; $display("FAIL mid_gnt got=%b exp=0100", rd_gnt);
        end
        tick();
        clear_inputs();
        rst = 1'b1;
        #1;
        checks++;
        if (rd_valid !== 4'b0000 || rd_data !== 8'h00) begin
            failures++; $display("FAIL mid_drop got=%b/%h exp=0000/00", rd_valid, rd_data);
        end
        tick();
        rst = 1'b0;
        wr_req = 4'b1111;
        rd_req = 4'b1111;
        #1;
        checks++;
        if (wr_gnt !== 4'b0001 || rd_gnt !== 4'b0001) begin
            failures++; $display("FAIL mid_ptr wg=%b rg=%b exp=0001/0001", wr_gnt, rd_gnt);
        end
        clear_inputs();
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (rd_valid !== 4'b0000) begin
                failures++; $display("FAIL mid_late[%0d] got=%b exp=0000", k, rd_valid);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_write_fairness();
        test_idle();
        test_read_latency();
        test_skip_wrap();
        test_collision();
        test_back_to_back();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
